alu_iterative: RTL and testbench
================================

Name: alu_iterative

Overview:
- Execution-stage ALU placed directly downstream of the ALU control decoder; consumes its 3-bit alu_control code and two operands, returns a registered result and a zero flag.
- add, sub, and, or, slt and the undefined codes complete in one cycle.
- mul runs on an iterative radix-2 shift-add multiplier (WIDTH iterations), so the block carries a valid/ready handshake toward the issuing logic.

Parameters:
- WIDTH, 32, operand and result width in bits (supported range 4..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operands and alu_control are valid this cycle
- in_ready  output  1  block can accept an operation; equals (state == IDLE)
- alu_control  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 mul; 100 and 111 undefined
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- result  output  WIDTH  registered result; holds its value until the next completion
- zero  output  1  registered, (result == 0), updated together with result
- out_valid  output  1  one-cycle pulse marking a new result/zero

Behaviour:
- Reset: asynchronous; forces state = IDLE, result = 0, zero = 0, out_valid = 0, and clears the internal accumulator, multiplicand, multiplier and counter. in_ready = 1 while rst is asserted.
- Accept: an operation is accepted on a rising edge where in_valid = 1 and in_ready = 1. in_valid is ignored while in_ready = 0; no queueing.
- State IDLE, non-mul op accepted:
  - on that same edge, result <= op(src_a, src_b), zero <= (that value == 0), out_valid <= 1; state stays IDLE.
  - Back-to-back accepts on consecutive edges are allowed, giving one result per cycle.
- Single-cycle arithmetic, all modulo 2^WIDTH:
  - add = a + b; sub = a - b.
  - and, or are bitwise.
  - slt = 1 if signed(a) < signed(b), else 0, zero-extended to WIDTH.
  - Codes 100 and 111 produce result 0 (zero = 1).
- State IDLE, mul (110) accepted:
  - load mcand <= src_a, mplier <= src_b, acc <= 0, count <= 0.
  - out_valid <= 0; state <= MUL; result and zero hold their previous values.
- State MUL, every edge:
  - acc_next = acc + (mplier[0] ? mcand : 0).
  - mcand <= mcand << 1 (truncated to WIDTH); mplier <= mplier >> 1 (logical).
  - acc <= acc_next; count <= count + 1.
  - When count == WIDTH-1 on that edge: result <= acc_next, zero <= (acc_next == 0), out_valid <= 1, state <= IDLE.
  - No early termination.
- Multiply semantics and timing:
  - mul returns the low WIDTH bits of the product (sign-agnostic).
  - out_valid is asserted WIDTH edges after the accept edge; in_ready is low for exactly WIDTH cycles.
  - A new operation may be accepted on the edge at which out_valid rises, because state is IDLE during that cycle.
- Counter: ceil(log2(WIDTH)) bits; it never wraps inside a multiply.
- out_valid is high for exactly one cycle per accepted operation; it is low otherwise.
- Reset during MUL aborts the multiply: no out_valid pulse, result = 0, and the block is ready on the first edge after rst deasserts.
- Operand or alu_control changes during MUL have no effect; only the values captured at accept are used.

Test Plan:
- Reset, then single-cycle ops:
  - in_valid with add 5, 7 -> result = 12, zero = 0, out_valid pulse on the next cycle.
  - sub 9, 9 -> result = 0, zero = 1.
- Back-to-back single-cycle ops on consecutive cycles: and 0xF0F0, 0x0FF0; or 0xF0F0, 0x000F; slt 0xFFFFFFFF, 1 -> results 0x00F0, 0xF0FF, 1 on three consecutive cycles; in_ready stays 1.
- mul 0x1234 × 0x10 (WIDTH = 32):
  - in_ready low for 32 cycles; out_valid exactly 32 edges after the accept edge; result = 0x12340.
  - in_valid with add, held during the busy window, is ignored and is accepted on the out_valid cycle.
- mul overflow and sign: mul 0xFFFFFFFF × 0xFFFFFFFF -> result = 0x00000001; mul 0x80000000 × 2 -> result = 0, zero = 1.
- Undefined codes 100 and 111 with nonzero operands -> result = 0, zero = 1, out_valid after 1 cycle.
- rst asserted mid-multiply (cycle 10 of a mul):
  - result = 0, out_valid never pulses, in_ready = 1 immediately.
  - add 1, 1 issued after reset deasserts -> result = 2.

Source files
------------

// File: rtl/alu_iterative.sv
// Execution-stage ALU: add/sub/and/or/slt finish in one cycle, mul runs on a
// radix-2 shift-add multiplier taking WIDTH cycles behind a valid/ready handshake.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             state_dbg
);

  // Handshake: an operation is taken on a rising edge where in_valid and
  // in_ready are both high; in_valid is ignored while in_ready is low.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] single_res;

  function automatic logic [WIDTH-1:0] alu_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    acc_next    = acc_q + (mplier_q[0] ? mcand_q : '0);
    single_res  = alu_op(alu_control, src_a, src_b);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (alu_control == OP_MUL) begin
            mcand_d  = src_a;
            mplier_d = src_b;
            acc_d    = '0;
            count_d  = '0;
            state_d  = MUL;
          end else begin
            result_d    = single_res;
            zero_d      = (single_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        // Fixed WIDTH iterations, no early exit, so latency is data-independent.
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CNT_LAST) begin
          result_d    = acc_next;
          zero_d      = (acc_next == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      count_q     <= count_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative (WIDTH = 32): single-cycle ops, back-to-back
// issue, multiply latency/handshake, undefined codes and reset mid-multiply.
module tb_alu_iterative;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_control;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic [W-1:0]  result;
  logic          zero;
  logic          out_valid;
  logic          state_dbg;

  int n_checks;
  int n_errors;

  alu_iterative #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .result      (result),
    .zero        (zero),
    .out_valid   (out_valid),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one single-cycle op on a negedge and checks the registered result
  // just after the accepting edge.
  task automatic single_op(input string tag, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input logic exp_zero);
    @(negedge clk);
    alu_control = op;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".result"},    64'(result),    64'(exp_res));
    check({tag, ".zero"},      64'(zero),      64'(exp_zero));
    check({tag, ".in_ready"},  64'(in_ready),  64'd1);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".out_valid_low"}, 64'(out_valid), 64'd0);
  endtask

  // Multiply with latency/handshake checks; optionally holds an add request
  // through the busy window and expects it taken on the out_valid cycle.
  task automatic mul_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic exp_zero,
                        input bit hold_add);
    int edges;
    int low_ready;
    @(negedge clk);
    alu_control = 3'b110;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".accept_no_valid"}, 64'(out_valid), 64'd0);
    low_ready = (in_ready == 1'b0) ? 1 : 0;
    if (hold_add) begin
      alu_control = 3'b000;
      src_a       = 32'd3;
      src_b       = 32'd4;
    end else begin
      in_valid = 1'b0;
    end
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) break;
      if (!in_ready) low_ready++;
    end
    check({tag, ".latency"},   64'(edges),     64'(W));
    check({tag, ".ready_low"}, 64'(low_ready), 64'(W));
    check({tag, ".result"},    64'(result),    64'(exp_res));
    check({tag, ".zero"},      64'(zero),      64'(exp_zero));
    check({tag, ".in_ready"},  64'(in_ready),  64'd1);
    if (hold_add) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, ".held_add_valid"},  64'(out_valid), 64'd1);
      check({tag, ".held_add_result"}, 64'(result),    64'd7);
    end
  endtask

  initial begin
    int pulses;
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    alu_control = 3'b000;
    src_a       = '0;
    src_b       = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready",  64'(in_ready),  64'd1);
    check("reset.result",    64'(result),    64'd0);
    check("reset.zero",      64'(zero),      64'd0);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    single_op("add_5_7", 3'b000, 32'd5, 32'd7, 32'd12, 1'b0);
    idle_cycle("add_5_7");
    single_op("sub_9_9", 3'b001, 32'd9, 32'd9, 32'd0, 1'b1);

    // Back-to-back issue on consecutive edges
    single_op("and_b2b", 3'b010, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0);
    single_op("or_b2b",  3'b011, 32'h0000_F0F0, 32'h0000_000F, 32'h0000_F0FF, 1'b0);
    single_op("slt_b2b", 3'b101, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
    single_op("slt_false", 3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    idle_cycle("slt_b2b");

    mul_op("mul_1234_10", 32'h1234, 32'h10, 32'h12340, 1'b0, 1'b1);
    idle_cycle("held_add");
    mul_op("mul_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    idle_cycle("mul_ff_ff");
    mul_op("mul_8000_2", 32'h8000_0000, 32'd2, 32'h0, 1'b1, 1'b0);

    single_op("undef_100", 3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1);
    single_op("pre_rst_add", 3'b000, 32'd2, 32'd3, 32'd5, 1'b0);
    single_op("undef_111", 3'b111, 32'hDEAD_BEEF, 32'h1, 32'd0, 1'b1);
    single_op("pre_rst_add2", 3'b000, 32'd2, 32'd3, 32'd5, 1'b0);

    // Reset in cycle 10 of a multiply
    @(negedge clk);
    alu_control = 3'b110;
    src_a       = 32'd3;
    src_b       = 32'd5;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid_mul.busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst.in_ready",  64'(in_ready),  64'd1);
    check("mid_rst.result",    64'(result),    64'd0);
    check("mid_rst.zero",      64'(zero),      64'd0);
    check("mid_rst.out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    alu_control = 3'b000;
    src_a       = 32'd1;
    src_b       = 32'd1;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_rst_add.out_valid", 64'(out_valid), 64'd1);
    check("post_rst_add.result",    64'(result),    64'd2);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("post_rst.no_stray_pulse", 64'(pulses), 64'd0);
    check("post_rst.result_hold",    64'(result), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
